// File: rtl/cic_upsampler.sv
// CIC interpolator: a comb section runs once per input sample, then a zero-stuffed
// integrator chain emits RATE output samples per input under valid/ready handshakes.
module cic_upsampler #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 16,
    parameter int RATE   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic signed [WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    localparam int LOG2R = $clog2(RATE);
    localparam int WI    = WIDTH + STAGES * LOG2R;
    localparam int SHIFT = (STAGES - 1) * LOG2R;
    localparam logic [LOG2R-1:0] LAST_PHASE = LOG2R'(RATE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [LOG2R-1:0]        phase_q, phase_d;
    logic signed [WI-1:0]    dly_q [STAGES];
    logic signed [WI-1:0]    dly_d [STAGES];
    logic signed [WI-1:0]    comb_reg_q, comb_reg_d;
    logic signed [WI-1:0]    integ_q [STAGES];
    logic signed [WI-1:0]    integ_d [STAGES];

    logic signed [WI-1:0]    comb_c [STAGES+1];
    logic signed [WI-1:0]    integ_nxt [STAGES];
    logic signed [WI-1:0]    integ_x;
    logic signed [WI-1:0]    shifted;
    logic                    rdy;
    logic                    vld;
    logic                    in_acc;
    logic                    out_acc;

    // Datapath: comb chain on the incoming sample, integrator chain on the stuffed stream.
    always_comb begin
        comb_c[0] = {{(WI-WIDTH){din[WIDTH-1]}}, din};
        for (int i = 0; i < STAGES; i++) begin
            comb_c[i+1] = comb_c[i] - dly_q[i];
        end
        integ_x      = (phase_q == '0) ? comb_reg_q : '0;
        integ_nxt[0] = integ_q[0] + integ_x;
        for (int k = 1; k < STAGES; k++) begin
            integ_nxt[k] = integ_q[k] + integ_nxt[k-1];
        end
        shifted = integ_nxt[STAGES-1] >>> SHIFT;
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dly_d      = dly_q;
        comb_reg_d = comb_reg_q;
        integ_d    = integ_q;
        rdy        = 1'b0;
        vld        = 1'b0;

        case (state_q)
            IDLE: rdy = 1'b1;
            RUN: begin
                vld = 1'b1;
                // New input only slots in as the last phase leaves, keeping output gapless.
                rdy = (phase_q == LAST_PHASE) && dout_ready;
            end
            default: rdy = 1'b0;
        endcase

        in_acc  = din_valid && rdy;
        out_acc = vld && dout_ready;

        if (out_acc) begin
            integ_d = integ_nxt;
            phase_d = phase_q + LOG2R'(1);
            if (phase_q == LAST_PHASE && !in_acc) begin
                state_d = IDLE;
            end
        end

        if (in_acc) begin
            for (int i = 0; i < STAGES; i++) begin
                dly_d[i] = comb_c[i];
            end
            comb_reg_d = comb_c[STAGES];
            phase_d    = '0;
            state_d    = RUN;
        end
    end

    assign din_ready  = rdy;
    assign dout_valid = vld;
    assign dout       = vld ? shifted[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            comb_reg_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dly_q[i]   <= '0;
                integ_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            comb_reg_q <= comb_reg_d;
            dly_q      <= dly_d;
            integ_q    <= integ_d;
        end
    end

endmodule

// File: doc/cic_upsampler.md
CIC_UPSAMPLER -- requirements
Module: cic_upsampler

Interface
REQ-001 The module SHALL have parameter STAGES, default 2, number of comb and integrator stages (1..4).
REQ-002 The module SHALL have parameter WIDTH, default 16, input/output sample width, two's complement.
REQ-003 The module SHALL have parameter RATE, default 4, interpolation factor, power of two, 2..64.
REQ-004 The module SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The module SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The module SHALL have port din  input  WIDTH  signed low-rate input sample.
REQ-007 The module SHALL have port din_valid  input  1  din holds a valid sample.
REQ-008 The module SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-009 The module SHALL have port dout  output  WIDTH  signed high-rate output sample.
REQ-010 The module SHALL have port dout_valid  output  1  dout holds a valid sample.
REQ-011 The module SHALL have port dout_ready  input  1  sink accepts dout this cycle.

Function
REQ-012 Input accept SHALL be din_valid && din_ready at a rising clk edge; output accept SHALL be dout_valid && dout_ready.
REQ-013 Internal width SHALL be WI = WIDTH + STAGES*log2(RATE); all comb/integrator arithmetic SHALL be signed, modulo 2^WI (wrap, no saturation).
REQ-014 Comb section (differential delay 1) SHALL run once per input accept: c0 = sign-extended din; ci = c(i-1) - d(i); d(i) <= c(i-1); result c(STAGES) registered into comb_reg.
REQ-015 FSM SHALL have states IDLE and RUN, plus phase counter 0..RATE-1.
REQ-016 IDLE: din_ready=1, dout_valid=0; on input accept -> RUN, phase=0.
REQ-017 RUN: dout_valid=1; integrator input x = comb_reg when phase==0, else 0 (zero stuffing).
REQ-018 Integrator next values SHALL be i0' = i0 + x, ik' = ik + i(k-1)' (combinational chain); dout = i(STAGES-1)' arithmetic-shifted right by (STAGES-1)*log2(RATE), truncated to WIDTH.
REQ-019 On output accept, integrators SHALL load next values and phase SHALL advance; without output accept, integrators, phase and dout SHALL hold.
REQ-020 In RUN, din_ready SHALL be 1 only when phase==RATE-1 && dout_ready; an input accept then SHALL set phase=0 and stay in RUN (gapless, one output per clock sustained).
REQ-021 Output accept at phase==RATE-1 without input accept SHALL return to IDLE; integrator state SHALL be retained.
REQ-022 dout SHALL be 0 whenever dout_valid=0.
REQ-023 Exactly RATE output samples SHALL be produced per accepted input; first output valid the cycle after input accept.
REQ-024 Sustained throughput SHALL be one input per RATE clocks with dout_ready held high and din_valid continuously high.

Reset
REQ-025 rst_n low SHALL asynchronously clear comb delays, comb_reg, integrators, phase to 0 and state to IDLE; din_ready=1, dout_valid=0, dout=0.
REQ-026 Reset asserted mid-burst SHALL discard remaining phases; first output after release SHALL come only from a new input accept.
REQ-027 Release of rst_n SHALL take effect on the next rising clk edge.

Verification (STAGES=2, WIDTH=16, RATE=4)
REQ-028 After reset, constant din=100, dout_ready=1 -> dout 25, 50, 75, 100, then 100 every cycle, din_ready pulsing every 4th cycle.
REQ-029 Impulse din=400 then din=0 continuously -> dout 100, 200, 300, 400, 300, 200, 100, 0, then 0.
REQ-030 Backpressure: dout_ready low 3 cycles during phase 1 of step test -> dout holds 50, phase and din_ready frozen, sequence resumes unchanged.
REQ-031 din=-32768 held constant -> dout settles to -32768 with internal wrap causing no glitch after the first 4 outputs.
REQ-032 rst_n pulsed low at phase 2 of a burst -> dout_valid=0, dout=0 immediately; next step din=100 reproduces 25, 50, 75, 100.
REQ-033 din_valid low after one sample of 100 -> exactly 4 outputs (25, 50, 75, 100), then IDLE with dout_valid=0.
